// File: rtl/qpsk_tx_framer.sv
// Packet framer feeding a QPSK modulator: buffers payload bytes, then emits
// preamble, sync word, payload and CRC-8 as 2-bit symbols on each mod_req.
module qpsk_tx_framer #(
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned PREAMBLE_SYMS = 16,
    parameter logic [15:0] SYNC_WORD     = 16'hD391
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       mod_req,
    output logic [1:0] symbol_out,
    output logic       symbol_en,
    output logic       busy,
    output logic       underrun,
    output logic [2:0] dbg_state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = ($clog2(PREAMBLE_SYMS + 1) > 4) ? $clog2(PREAMBLE_SYMS + 1) : 4;

    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [PW-1:0] PRE_LEN  = PW'(PREAMBLE_SYMS);
    localparam logic [PW-1:0] SYNC_LEN = PW'(8);
    localparam logic [PW-1:0] BYTE_LEN = PW'(4);
    localparam logic [PW-1:0] P_ONE    = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_SYNC     = 3'd2,
        S_PAYLOAD  = 3'd3,
        S_CRC      = 3'd4
    } state_e;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Byte FIFO. Handshake: a byte transfers on a rising edge where s_valid and
    // s_ready are both high; s_valid may not depend on s_ready.
    logic [8:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] last_cnt_q, last_cnt_d;
    logic [AW:0] count;
    logic        ready_en_q;
    logic        full, empty, push, pop;
    logic [8:0]  head;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign s_ready = ready_en_q & ~full;
    assign push    = s_valid & s_ready;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_last, s_data};
        end
    end

    // Number of last-flagged bytes buffered; nonzero means a whole frame is queued.
    always_comb begin
        last_cnt_d = last_cnt_q;
        if (push && s_last) begin
            last_cnt_d = last_cnt_d + PTR_ONE;
        end
        if (pop && head[8]) begin
            last_cnt_d = last_cnt_d - PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_cnt_q <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            last_cnt_q <= last_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Sequencer: state names the field that the symbol in symbol_out belongs to.
    state_e        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [15:0]   shreg_q, shreg_d;
    logic          last_byte_q, last_byte_d;
    logic [7:0]    crc_q, crc_d;
    logic [1:0]    sym_q, sym_d;
    logic          en_q, en_d;
    logic          busy_q;
    logic          unr_q, unr_d;
    logic          take_byte;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        shreg_d     = shreg_q;
        last_byte_d = last_byte_q;
        crc_d       = crc_q;
        sym_d       = sym_q;
        en_d        = en_q;
        unr_d       = 1'b0;
        pop         = 1'b0;
        take_byte   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (last_cnt_q != '0 || full) begin
                    state_d = S_PREAMBLE;
                    en_d    = 1'b1;
                    sym_d   = 2'b00;
                    pos_d   = P_ONE;
                    crc_d   = 8'h00;
                end
            end
            S_PREAMBLE: begin
                if (mod_req) begin
                    if (pos_q != PRE_LEN) begin
                        sym_d = pos_q[0] ? 2'b11 : 2'b00;
                        pos_d = pos_q + P_ONE;
                    end else begin
                        state_d = S_SYNC;
                        sym_d   = SYNC_WORD[15:14];
                        shreg_d = {SYNC_WORD[13:0], 2'b00};
                        pos_d   = P_ONE;
                    end
                end
            end
            S_SYNC: begin
                if (mod_req) begin
                    if (pos_q != SYNC_LEN) begin
                        sym_d   = shreg_q[15:14];
                        shreg_d = {shreg_q[13:0], 2'b00};
                        pos_d   = pos_q + P_ONE;
                    end else begin
                        take_byte = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (mod_req) begin
                    if (pos_q != BYTE_LEN) begin
                        sym_d   = shreg_q[15:14];
                        shreg_d = {shreg_q[13:0], 2'b00};
                        pos_d   = pos_q + P_ONE;
                    end else if (last_byte_q) begin
                        state_d = S_CRC;
                        sym_d   = crc_q[7:6];
                        shreg_d = {crc_q[5:0], 10'b0};
                        pos_d   = P_ONE;
                    end else begin
                        take_byte = 1'b1;
                    end
                end
            end
            S_CRC: begin
                if (mod_req) begin
                    if (pos_q != BYTE_LEN) begin
                        sym_d   = shreg_q[15:14];
                        shreg_d = {shreg_q[13:0], 2'b00};
                        pos_d   = pos_q + P_ONE;
                    end else begin
                        state_d = S_IDLE;
                        en_d    = 1'b0;
                        sym_d   = 2'b00;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                sym_d   = 2'b00;
            end
        endcase

        // Byte boundary: an empty FIFO sends a filler and retries on the next request.
        if (take_byte) begin
            if (empty) begin
                sym_d = 2'b00;
                unr_d = 1'b1;
            end else begin
                pop         = 1'b1;
                state_d     = S_PAYLOAD;
                sym_d       = head[7:6];
                shreg_d     = {head[5:0], 10'b0};
                last_byte_d = head[8];
                crc_d       = crc8_byte(crc_q, head[7:0]);
                pos_d       = P_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            shreg_q     <= '0;
            last_byte_q <= 1'b0;
            crc_q       <= 8'h00;
            sym_q       <= 2'b00;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            unr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            shreg_q     <= shreg_d;
            last_byte_q <= last_byte_d;
            crc_q       <= crc_d;
            sym_q       <= sym_d;
            en_q        <= en_d;
            busy_q      <= (state_d != S_IDLE);
            unr_q       <= unr_d;
        end
    end

    assign symbol_out  = sym_q;
    assign symbol_en   = en_q;
    assign busy        = busy_q;
    assign underrun    = unr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_qpsk_tx_framer.sv
// Directed-plus-random bench for qpsk_tx_framer; expected symbol streams come
// from a frame-level model (preamble/sync/payload lists, CRC by long division).
module tb_qpsk_tx_framer;
    localparam int          PRE = 16;
    localparam logic [15:0] SW  = 16'hD391;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic       mod_req;
    logic [1:0] symbol_out;
    logic       symbol_en;
    logic       busy;
    logic       underrun;
    logic [2:0] dbg_state;

    qpsk_tx_framer #(.FIFO_DEPTH(16), .PREAMBLE_SYMS(PRE), .SYNC_WORD(SW)) dut (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready), .mod_req(mod_req),
        .symbol_out(symbol_out), .symbol_en(symbol_en), .busy(busy),
        .underrun(underrun), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    logic [8:0] in_q[$];
    logic [8:0] late_q[$];
    logic [1:0] exp_q[$];
    logic [8:0] dropped;
    int tests_run = 0;
    int tests_failed = 0;
    int accepted = 0;
    int unr_seen = 0;
    logic [1:0] obs_sym, obs_hold;
    logic       obs_en, obs_unr, obs_unr_after;

    // Byte source: presents the head of in_q, retires it on an accepted edge.
    always @(negedge clk) begin
        if (in_q.size() > 0) begin
            s_valid = 1'b1;
            s_data  = in_q[0][7:0];
            s_last  = in_q[0][8];
        end else begin
            s_valid = 1'b0;
            s_data  = 8'h00;
            s_last  = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (s_valid && s_ready && reset_n && in_q.size() > 0) begin
            dropped = in_q.pop_front();
            accepted++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_expected(input logic [7:0] bytes[$]);
        logic [8:0]  r;
        logic [15:0] sw;
        logic [7:0]  b;
        sw = SW;
        r  = 9'h000;
        for (int i = 0; i < PRE; i++) exp_q.push_back((i % 2 == 1) ? 2'b11 : 2'b00);
        for (int i = 0; i < 8; i++) exp_q.push_back(sw[15 - 2*i -: 2]);
        foreach (bytes[i]) begin
            b = bytes[i];
            for (int k = 0; k < 4; k++) exp_q.push_back(b[7 - 2*k -: 2]);
            for (int j = 7; j >= 0; j--) begin
                r = {r[7:0], b[j]};
                if (r[8]) r = r ^ 9'h107;
            end
        end
        for (int j = 0; j < 8; j++) begin
            r = {r[7:0], 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        b = r[7:0];
        for (int k = 0; k < 4; k++) exp_q.push_back(b[7 - 2*k -: 2]);
    endtask

    task automatic pulse(input int gap);
        @(negedge clk); mod_req = 1'b1;
        @(posedge clk); #1;
        obs_sym = symbol_out; obs_en = symbol_en; obs_unr = underrun;
        @(negedge clk); mod_req = 1'b0;
        @(posedge clk); #1;
        obs_hold = symbol_out; obs_unr_after = underrun;
        repeat (gap - 1) @(posedge clk);
    endtask

    task automatic wait_start();
        int n = 0;
        while (!symbol_en && n < 300) begin
            @(posedge clk); #1; n++;
        end
        check("frame_start", symbol_en, 1);
    endtask

    task automatic run_frame(input int gap, input logic expect_next);
        logic [1:0] e;
        int guard = 0;
        wait_start();
        check("busy_on_start", busy, 1);
        e = exp_q.pop_front();
        check("first_sym", symbol_out, e);
        while (exp_q.size() > 0 && guard < 2000) begin
            pulse(gap);
            guard++;
            if (obs_unr) begin
                unr_seen++;
                check("filler_sym", obs_sym, 0);
                check("underrun_width", obs_unr_after, 0);
                if (unr_seen == 2 && late_q.size() > 0) in_q.push_back(late_q.pop_front());
            end else begin
                e = exp_q.pop_front();
                check("sym", obs_sym, e);
                check("sym_en", obs_en, 1);
                check("sym_hold", obs_hold, e);
            end
        end
        check("frame_len", exp_q.size(), 0);
        @(negedge clk); mod_req = 1'b1;
        @(posedge clk); #1;
        check("end_en", symbol_en, 0);
        check("end_sym", symbol_out, 0);
        check("end_busy", busy, 0);
        @(negedge clk); mod_req = 1'b0;
        @(posedge clk); #1;
        check("next_en", symbol_en, expect_next);
        check("next_busy", busy, expect_next);
    endtask

    initial begin
        logic [7:0] fb[$];
        logic [7:0] fb2[$];
        int len;

        reset_n = 1'b0;
        mod_req = 1'b0;
        #1;
        check("rst_sym", symbol_out, 0);
        check("rst_en", symbol_en, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", s_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        #1 check("ready_before_edge", s_ready, 0);
        @(posedge clk); #1;
        check("ready_after_edge", s_ready, 1);

        // Requests with nothing queued must not start anything
        pulse(2);
        check("idle_req_en", obs_en, 0);
        check("idle_req_sym", obs_sym, 0);
        check("idle_req_busy", busy, 0);

        // Single 0xA5 frame, request every 100 clocks
        fb = '{8'hA5};
        build_expected(fb);
        in_q.push_back({1'b1, 8'hA5});
        unr_seen = 0;
        run_frame(100, 1'b0);
        check("a5_no_underrun", unr_seen, 0);

        // Random frames
        for (int f = 0; f < 4; f++) begin
            fb.delete();
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) fb.push_back(8'($urandom_range(0, 255)));
            for (int i = 0; i < len; i++) in_q.push_back({(i == len - 1), fb[i]});
            build_expected(fb);
            unr_seen = 0;
            run_frame($urandom_range(1, 5), 1'b0);
            check("rand_no_underrun", unr_seen, 0);
        end

        // Backpressure: 20 unterminated bytes, no requests
        fb.delete();
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            fb.push_back(8'($urandom_range(0, 255)));
            in_q.push_back({1'b0, fb[i]});
        end
        repeat (40) @(posedge clk);
        #1;
        check("bp_accepted", accepted, 16);
        check("bp_ready_low", s_ready, 0);
        check("bp_busy", busy, 1);
        check("bp_en", symbol_en, 1);
        fb.push_back(8'h5A);
        in_q.push_back({1'b1, 8'h5A});
        build_expected(fb);
        unr_seen = 0;
        run_frame(4, 1'b0);
        check("bp_no_underrun", unr_seen, 0);

        // Underrun: full-started frame whose last byte arrives late
        fb.delete();
        for (int i = 0; i < 16; i++) begin
            fb.push_back(8'($urandom_range(0, 255)));
            in_q.push_back({1'b0, fb[i]});
        end
        fb.push_back(8'hC3);
        late_q.push_back({1'b1, 8'hC3});
        build_expected(fb);
        unr_seen = 0;
        run_frame(4, 1'b0);
        check("underrun_seen", (unr_seen >= 2), 1);

        // Reset during SYNC with extra bytes buffered
        in_q.push_back({1'b1, 8'hA5});
        in_q.push_back({1'b0, 8'h3C});
        wait_start();
        for (int i = 0; i < 17; i++) pulse(2);
        check("pre_reset_busy", busy, 1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_sym", symbol_out, 0);
        check("mid_rst_en", symbol_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_ready", s_ready, 0);
        in_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", s_ready, 1);
        repeat (5) @(posedge clk);
        #1 check("post_rst_idle", busy, 0);
        fb = '{8'hA5};
        build_expected(fb);
        in_q.push_back({1'b1, 8'hA5});
        unr_seen = 0;
        run_frame(3, 1'b0);
        check("post_rst_no_underrun", unr_seen, 0);

        // Back-to-back frames, both queued before the first ends
        fb.delete();
        fb2.delete();
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) fb.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < len; i++) in_q.push_back({(i == len - 1), fb[i]});
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) fb2.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < len; i++) in_q.push_back({(i == len - 1), fb2[i]});
        build_expected(fb);
        unr_seen = 0;
        run_frame(2, 1'b1);
        build_expected(fb2);
        run_frame(2, 1'b0);
        check("b2b_no_underrun", unr_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
